// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider: 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per clock, start/done/overflow handshake.
module sequential_divider #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset_in,
    input  logic               start_in,
    input  logic [2*WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0]   divisor_in,
    output logic [WIDTH-1:0]   quotient_out,
    output logic [WIDTH-1:0]   remainder_out,
    output logic               done_out,
    output logic               busy_out,
    output logic               overflow_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic             r_pend;
    logic [WIDTH-1:0] r_quo_out;
    logic [WIDTH-1:0] r_rem_out;
    logic             r_done;
    logic             r_busy;
    logic             r_ovf;

    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_dvs_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_pend_nxt;
    logic [WIDTH-1:0] w_quo_out_nxt;
    logic [WIDTH-1:0] w_rem_out_nxt;
    logic             w_done_nxt;
    logic             w_busy_nxt;
    logic             w_ovf_nxt;

    logic             w_accept;
    logic             w_ovf_req;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_quo_step;

    // Start is taken in IDLE/DONE, but not while an overflow result is pending.
    assign w_accept = start_in && !r_pend &&
                      ((r_state == S_IDLE) || (r_state == S_DONE));

    // Quotient cannot fit in WIDTH bits when the upper half reaches the divisor.
    assign w_ovf_req = (divisor_in == '0) ||
                       (dividend_in[2*WIDTH-1:WIDTH] >= divisor_in);

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // One restoring step: shift {R,Q} left, trial-subtract the divisor.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_sub      = w_shift[WIDTH-1:0] - r_dvs;
    assign w_rem_step = w_ge ? w_sub : w_shift[WIDTH-1:0];
    assign w_quo_step = {r_quo[WIDTH-2:0], w_ge};

    // State register.
    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_ovf_req ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        w_rem_nxt     = r_rem;
        w_quo_nxt     = r_quo;
        w_dvs_nxt     = r_dvs;
        w_cnt_nxt     = r_cnt;
        w_pend_nxt    = r_pend;
        w_quo_out_nxt = r_quo_out;
        w_rem_out_nxt = r_rem_out;
        w_done_nxt    = r_done;
        w_busy_nxt    = r_busy;
        w_ovf_nxt     = r_ovf;
        unique case (1'b1)
            w_accept: begin
                w_dvs_nxt     = divisor_in;
                w_rem_nxt     = dividend_in[2*WIDTH-1:WIDTH];
                w_quo_nxt     = dividend_in[WIDTH-1:0];
                w_cnt_nxt     = '0;
                w_quo_out_nxt = '0;
                w_rem_out_nxt = '0;
                w_done_nxt    = 1'b0;
                w_ovf_nxt     = 1'b0;
                w_busy_nxt    = !w_ovf_req;
                w_pend_nxt    = w_ovf_req;
            end
            r_pend: begin
                w_pend_nxt = 1'b0;
                w_done_nxt = 1'b1;
                w_ovf_nxt  = 1'b1;
            end
            (r_state == S_CALC): begin
                w_rem_nxt = w_rem_step;
                w_quo_nxt = w_quo_step;
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_last) begin
                    w_quo_out_nxt = w_quo_step;
                    w_rem_out_nxt = w_rem_step;
                    w_ovf_nxt     = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_busy_nxt    = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_cnt     <= '0;
            r_pend    <= 1'b0;
            r_quo_out <= '0;
            r_rem_out <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_rem     <= w_rem_nxt;
            r_quo     <= w_quo_nxt;
            r_dvs     <= w_dvs_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pend    <= w_pend_nxt;
            r_quo_out <= w_quo_out_nxt;
            r_rem_out <= w_rem_out_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= w_busy_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    assign quotient_out  = r_quo_out;
    assign remainder_out = r_rem_out;
    assign done_out      = r_done;
    assign busy_out      = r_busy;
    assign overflow_out  = r_ovf;

endmodule
